// File: rtl/pipe_ctrl_chain_pkg.sv
// Shared types and constants for the control-word pipeline and its long-op sequencer.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    LO_IDLE = 2'd0,
    LO_WAIT = 2'd1,
    LO_DONE = 2'd2
  } long_state_e;

  localparam int unsigned STG_E = 0;
  localparam int unsigned STG_M = 1;
  localparam int unsigned STG_W = 2;

endpackage

// File: rtl/pipe_ctrl_chain_if.sv
// Handshake bundle between decode/hazard logic and the control pipeline.
interface pipe_ctrl_chain_if #(
  parameter int unsigned CTRL_W = 16,
  parameter int unsigned STAGES = 3
);

  logic [CTRL_W-1:0]        ctrlD;
  logic                     validD;
  logic                     longopD;
  logic [STAGES-1:0]        stall_i;
  logic [STAGES-1:0]        flush_i;
  logic                     long_done_i;
  logic [STAGES*CTRL_W-1:0] ctrl_o;
  logic [STAGES-1:0]        valid_o;
  logic                     long_start_o;
  logic                     stall_req_o;
  logic                     long_abort_o;
  logic                     long_timeout_o;

  modport master (
    output ctrlD, validD, longopD, stall_i, flush_i, long_done_i,
    input  ctrl_o, valid_o, long_start_o, stall_req_o, long_abort_o, long_timeout_o
  );

  modport slave (
    input  ctrlD, validD, longopD, stall_i, flush_i, long_done_i,
    output ctrl_o, valid_o, long_start_o, stall_req_o, long_abort_o, long_timeout_o
  );

endinterface

// File: rtl/pipe_ctrl_chain_long_op_fsm.sv
// Long-op sequencer: start pulse, stage-0 hold, watchdog, abort on flush, sticky timeout.
module long_op_fsm
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned LONG_MAX = 64,
  parameter int unsigned CNT_W    = 7
) (
  input  logic clk,
  input  logic rst,
  input  logic go_i,
  input  logic flush0_i,
  input  logic ext_stall0_i,
  input  logic done_i,
  output logic hold_o,
  output logic start_o,
  output logic abort_o,
  output logic timeout_o
);

  long_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
  logic             cnt_last;

  assign cnt_last  = (cnt_q == CNT_W'(LONG_MAX - 1));
  assign timeout_o = timeout_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= LO_IDLE;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  // Flush outranks done, done outranks the watchdog.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    case (state_q)
      LO_IDLE: begin
        if (go_i && !flush0_i) begin
          state_d = LO_WAIT;
          cnt_d   = '0;
        end
      end
      LO_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (flush0_i) begin
          state_d = LO_IDLE;
        end else if (done_i) begin
          state_d = ext_stall0_i ? LO_DONE : LO_IDLE;
        end else if (cnt_last) begin
          state_d   = LO_IDLE;
          timeout_d = 1'b1;
        end
      end
      LO_DONE: begin
        if (flush0_i || !ext_stall0_i) state_d = LO_IDLE;
      end
      default: state_d = LO_IDLE;
    endcase
  end

  // Hold drops on the watchdog cycle so stage 0 leaves instead of re-triggering.
  always_comb begin
    hold_o  = 1'b0;
    start_o = 1'b0;
    abort_o = 1'b0;
    case (state_q)
      LO_IDLE: begin
        if (go_i && !flush0_i) begin
          start_o = 1'b1;
          hold_o  = 1'b1;
        end
      end
      LO_WAIT: begin
        hold_o  = !done_i && !cnt_last;
        abort_o = flush0_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/pipe_ctrl_chain.sv
// Control-word pipeline after decode: per-stage stall/flush/valid plus long-op stage-0 hold.
module pipe_ctrl_chain
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned CTRL_W   = 16,
  parameter int unsigned STAGES   = 3,
  parameter int unsigned LONG_MAX = 64,
  localparam int unsigned CNT_W   = $clog2(LONG_MAX + 1)
) (
  input  logic clk,
  input  logic rst,
  pipe_ctrl_chain_if.slave bus
);

  logic [STAGES-1:0] ext;
  logic [STAGES-1:0] es;
  logic [STAGES-1:0] stg_valid;
  logic [CTRL_W-1:0] stg_ctrl [STAGES];
  logic              hold;
  logic              go;
  logic              longop0_q, longop0_d;

  // A stall at stage k freezes every earlier stage as well.
  always_comb begin
    ext = '0;
    for (int unsigned k = 0; k < STAGES; k++) begin
      ext[k] = |(bus.stall_i >> k);
    end
  end

  always_comb begin
    es        = ext;
    es[STG_E] = ext[STG_E] | hold;
  end

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    logic [CTRL_W-1:0] ctrl_q, ctrl_d, src_ctrl;
    logic              valid_q, valid_d, src_valid, bubble;

    if (g == 0) begin : g_head
      assign src_ctrl  = bus.ctrlD;
      assign src_valid = bus.validD;
      assign bubble    = 1'b0;
    end else begin : g_body
      assign src_ctrl  = stg_ctrl[g-1];
      assign src_valid = stg_valid[g-1];
      assign bubble    = es[g-1];
    end

    always_comb begin
      ctrl_d  = ctrl_q;
      valid_d = valid_q;
      if (bus.flush_i[g]) begin
        ctrl_d  = '0;
        valid_d = 1'b0;
      end else if (!es[g]) begin
        if (bubble) begin
          ctrl_d  = '0;
          valid_d = 1'b0;
        end else begin
          ctrl_d  = src_ctrl;
          valid_d = src_valid;
        end
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        ctrl_q  <= '0;
        valid_q <= 1'b0;
      end else begin
        ctrl_q  <= ctrl_d;
        valid_q <= valid_d;
      end
    end

    assign stg_ctrl[g]                     = ctrl_q;
    assign stg_valid[g]                    = valid_q;
    assign bus.ctrl_o[g*CTRL_W +: CTRL_W]  = ctrl_q;
  end

  assign bus.valid_o = stg_valid;

  always_comb begin
    longop0_d = longop0_q;
    if (bus.flush_i[STG_E]) begin
      longop0_d = 1'b0;
    end else if (!es[STG_E]) begin
      longop0_d = bus.longopD;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) longop0_q <= 1'b0;
    else     longop0_q <= longop0_d;
  end

  assign go = stg_valid[STG_E] & longop0_q;

  long_op_fsm #(
    .LONG_MAX (LONG_MAX),
    .CNT_W    (CNT_W)
  ) u_long_op (
    .clk          (clk),
    .rst          (rst),
    .go_i         (go),
    .flush0_i     (bus.flush_i[STG_E]),
    .ext_stall0_i (ext[STG_E]),
    .done_i       (bus.long_done_i),
    .hold_o       (hold),
    .start_o      (bus.long_start_o),
    .abort_o      (bus.long_abort_o),
    .timeout_o    (bus.long_timeout_o)
  );

  assign bus.stall_req_o = hold;

endmodule

// File: tb/tb_pipe_ctrl_chain.sv
// Directed bench for pipe_ctrl_chain: streaming, stalls, flushes and the long-op handshake.
module tb_pipe_ctrl_chain;

  localparam int unsigned CW = 16;
  localparam int unsigned NS = 3;
  localparam int unsigned LM = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;

  pipe_ctrl_chain_if #(.CTRL_W(CW), .STAGES(NS)) bus ();

  pipe_ctrl_chain #(
    .CTRL_W   (CW),
    .STAGES   (NS),
    .LONG_MAX (LM)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [CW-1:0] stg(input int k);
    return bus.ctrl_o[k*CW +: CW];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    bus.ctrlD       = '0;
    bus.validD      = 1'b0;
    bus.longopD     = 1'b0;
    bus.stall_i     = '0;
    bus.flush_i     = '0;
    bus.long_done_i = 1'b0;
  endtask

  task automatic drain();
    idle_inputs();
    repeat (4) tick();
  endtask

  task automatic load_longop(input logic [CW-1:0] w);
    bus.ctrlD   = w;
    bus.validD  = 1'b1;
    bus.longopD = 1'b1;
    tick();
    idle_inputs();
  endtask

  task automatic test_reset();
    idle_inputs();
    #1 rst = 1'b1;
    tick();
    tick();
    checks++; if (bus.valid_o !== 3'b000) begin errors++; $display("FAIL reset_valid: got %b expected 000", bus.valid_o); end
    checks++; if (bus.ctrl_o !== '0) begin errors++; $display("FAIL reset_ctrl: got %h expected 0", bus.ctrl_o); end
    checks++; if (bus.stall_req_o !== 1'b0) begin errors++; $display("FAIL reset_stall_req: got %b expected 0", bus.stall_req_o); end
    checks++; if (bus.long_start_o !== 1'b0) begin errors++; $display("FAIL reset_start: got %b expected 0", bus.long_start_o); end
    checks++; if (bus.long_abort_o !== 1'b0) begin errors++; $display("FAIL reset_abort: got %b expected 0", bus.long_abort_o); end
    checks++; if (bus.long_timeout_o !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b expected 0", bus.long_timeout_o); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_stream();
    logic [CW-1:0] e0, e2;
    logic          v2;
    int            j;
    for (int c = 0; c < 8; c++) begin
      bus.ctrlD  = (c < 5) ? CW'(c + 1) : '0;
      bus.validD = (c < 5);
      tick();
      e0 = (c < 5) ? CW'(c + 1) : '0;
      j  = c - 2;
      e2 = (j >= 0 && j < 5) ? CW'(j + 1) : '0;
      v2 = (j >= 0 && j < 5);
      checks++; if (stg(0) !== e0) begin errors++; $display("FAIL stream_s0 c=%0d: got %h expected %h", c, stg(0), e0); end
      checks++; if (stg(2) !== e2) begin errors++; $display("FAIL stream_s2 c=%0d: got %h expected %h", c, stg(2), e2); end
      checks++; if (bus.valid_o[2] !== v2) begin errors++; $display("FAIL stream_v2 c=%0d: got %b expected %b", c, bus.valid_o[2], v2); end
    end
    drain();
  endtask

  task automatic test_stall_mid();
    logic [CW-1:0] w [3];
    w = '{16'h0011, 16'h0022, 16'h0033};
    for (int i = 0; i < 3; i++) begin
      bus.ctrlD  = w[i];
      bus.validD = 1'b1;
      tick();
    end
    bus.ctrlD   = 16'h0044;
    bus.stall_i = 3'b010;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (stg(0) !== 16'h0033) begin errors++; $display("FAIL stall_s0 i=%0d: got %h expected 0033", i, stg(0)); end
      checks++; if (stg(1) !== 16'h0022) begin errors++; $display("FAIL stall_s1 i=%0d: got %h expected 0022", i, stg(1)); end
      checks++; if (stg(2) !== 16'h0000) begin errors++; $display("FAIL stall_s2_bubble i=%0d: got %h expected 0000", i, stg(2)); end
      checks++; if (bus.valid_o !== 3'b011) begin errors++; $display("FAIL stall_valid i=%0d: got %b expected 011", i, bus.valid_o); end
    end
    bus.stall_i = 3'b000;
    tick();
    checks++; if (stg(0) !== 16'h0044) begin errors++; $display("FAIL stall_rel_s0: got %h expected 0044", stg(0)); end
    checks++; if (stg(1) !== 16'h0033) begin errors++; $display("FAIL stall_rel_s1: got %h expected 0033", stg(1)); end
    checks++; if (stg(2) !== 16'h0022) begin errors++; $display("FAIL stall_rel_s2: got %h expected 0022", stg(2)); end
    checks++; if (bus.valid_o !== 3'b111) begin errors++; $display("FAIL stall_rel_valid: got %b expected 111", bus.valid_o); end
    drain();
  endtask

  task automatic test_flush_beats_stall();
    bus.validD = 1'b1;
    bus.ctrlD  = 16'h0054;
    tick();
    bus.ctrlD  = 16'h0055;
    tick();
    bus.ctrlD   = 16'h0066;
    bus.stall_i = 3'b001;
    bus.flush_i = 3'b001;
    tick();
    checks++; if (stg(0) !== 16'h0000) begin errors++; $display("FAIL flush_s0_ctrl: got %h expected 0000", stg(0)); end
    checks++; if (stg(1) !== 16'h0000) begin errors++; $display("FAIL flush_s1_bubble: got %h expected 0000", stg(1)); end
    checks++; if (stg(2) !== 16'h0054) begin errors++; $display("FAIL flush_s2: got %h expected 0054", stg(2)); end
    checks++; if (bus.valid_o !== 3'b100) begin errors++; $display("FAIL flush_valid: got %b expected 100", bus.valid_o); end
    drain();
  endtask

  task automatic test_longop();
    int starts = 0;
    int holds  = 0;
    load_longop(16'h000A);
    bus.ctrlD  = 16'h000B;
    bus.validD = 1'b1;
    for (int t = 0; t < 8; t++) begin
      bus.long_done_i = (t == 5);
      settle();
      if (bus.long_start_o === 1'b1) starts++;
      if (bus.stall_req_o === 1'b1) holds++;
      if (t == 5) begin
        checks++; if (bus.stall_req_o !== 1'b0) begin errors++; $display("FAIL longop_hold_drop: got %b expected 0", bus.stall_req_o); end
      end
      tick();
      if (t == 4) begin
        checks++; if (stg(0) !== 16'h000A) begin errors++; $display("FAIL longop_s0_held: got %h expected 000A", stg(0)); end
        checks++; if (stg(1) !== 16'h0000) begin errors++; $display("FAIL longop_s1_bubble: got %h expected 0000", stg(1)); end
      end
      if (t == 5) begin
        checks++; if (stg(0) !== 16'h000B) begin errors++; $display("FAIL longop_s0_adv: got %h expected 000B", stg(0)); end
        checks++; if (stg(1) !== 16'h000A) begin errors++; $display("FAIL longop_s1_adv: got %h expected 000A", stg(1)); end
      end
    end
    checks++; if (starts !== 1) begin errors++; $display("FAIL longop_starts: got %0d expected 1", starts); end
    checks++; if (holds !== 5) begin errors++; $display("FAIL longop_hold_cycles: got %0d expected 5", holds); end
    drain();
  endtask

  task automatic test_longop_ext_stall();
    int starts = 0;
    load_longop(16'h000C);
    bus.ctrlD  = 16'h000D;
    bus.validD = 1'b1;
    for (int t = 0; t < 8; t++) begin
      bus.stall_i     = (t >= 3 && t <= 5) ? 3'b010 : 3'b000;
      bus.long_done_i = (t == 3);
      settle();
      if (bus.long_start_o === 1'b1) starts++;
      if (t == 4) begin
        checks++; if (bus.stall_req_o !== 1'b0) begin errors++; $display("FAIL done_state_hold: got %b expected 0", bus.stall_req_o); end
      end
      tick();
      if (t == 5) begin
        checks++; if (stg(0) !== 16'h000C) begin errors++; $display("FAIL done_s0_frozen: got %h expected 000C", stg(0)); end
      end
      if (t == 6) begin
        checks++; if (stg(0) !== 16'h000D) begin errors++; $display("FAIL done_s0_adv: got %h expected 000D", stg(0)); end
        checks++; if (stg(1) !== 16'h000C) begin errors++; $display("FAIL done_s1_adv: got %h expected 000C", stg(1)); end
      end
    end
    checks++; if (starts !== 1) begin errors++; $display("FAIL done_starts: got %0d expected 1", starts); end
    drain();
  endtask

  task automatic test_timeout_abort();
    load_longop(16'h000E);
    settle();
    checks++; if (bus.long_start_o !== 1'b1) begin errors++; $display("FAIL abort_start: got %b expected 1", bus.long_start_o); end
    tick();
    tick();
    tick();
    bus.flush_i = 3'b001;
    settle();
    checks++; if (bus.long_abort_o !== 1'b1) begin errors++; $display("FAIL abort_pulse: got %b expected 1", bus.long_abort_o); end
    tick();
    bus.flush_i = 3'b000;
    settle();
    checks++; if (bus.long_abort_o !== 1'b0) begin errors++; $display("FAIL abort_clear: got %b expected 0", bus.long_abort_o); end
    checks++; if (bus.stall_req_o !== 1'b0) begin errors++; $display("FAIL abort_hold: got %b expected 0", bus.stall_req_o); end
    checks++; if (bus.valid_o[0] !== 1'b0) begin errors++; $display("FAIL abort_s0_valid: got %b expected 0", bus.valid_o[0]); end
    checks++; if (bus.long_timeout_o !== 1'b0) begin errors++; $display("FAIL abort_timeout: got %b expected 0", bus.long_timeout_o); end
    drain();

    load_longop(16'h000F);
    for (int t = 0; t < 10; t++) begin
      settle();
      if (t == 7) begin
        checks++; if (bus.stall_req_o !== 1'b1) begin errors++; $display("FAIL wdog_hold_t7: got %b expected 1", bus.stall_req_o); end
      end
      if (t == 8) begin
        checks++; if (bus.stall_req_o !== 1'b0) begin errors++; $display("FAIL wdog_hold_t8: got %b expected 0", bus.stall_req_o); end
      end
      if (t == 9) begin
        checks++; if (bus.long_start_o !== 1'b0) begin errors++; $display("FAIL wdog_restart: got %b expected 0", bus.long_start_o); end
      end
      tick();
      if (t == 7) begin
        checks++; if (bus.long_timeout_o !== 1'b0) begin errors++; $display("FAIL wdog_early: got %b expected 0", bus.long_timeout_o); end
      end
      if (t == 8) begin
        checks++; if (bus.long_timeout_o !== 1'b1) begin errors++; $display("FAIL wdog_set: got %b expected 1", bus.long_timeout_o); end
      end
    end
    repeat (3) tick();
    checks++; if (bus.long_timeout_o !== 1'b1) begin errors++; $display("FAIL wdog_sticky: got %b expected 1", bus.long_timeout_o); end

    load_longop(16'h0010);
    tick();
    rst = 1'b1;
    settle();
    checks++; if (bus.long_abort_o !== 1'b0) begin errors++; $display("FAIL rst_mid_abort: got %b expected 0", bus.long_abort_o); end
    checks++; if (bus.stall_req_o !== 1'b0) begin errors++; $display("FAIL rst_mid_hold: got %b expected 0", bus.stall_req_o); end
    checks++; if (bus.long_timeout_o !== 1'b0) begin errors++; $display("FAIL rst_timeout_clear: got %b expected 0", bus.long_timeout_o); end
    checks++; if (bus.valid_o !== 3'b000) begin errors++; $display("FAIL rst_mid_valid: got %b expected 000", bus.valid_o); end
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_stream();
    test_stall_mid();
    test_flush_beats_stall();
    test_longop();
    test_longop_ext_stall();
    test_timeout_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
